lfsr_checker: RTL and testbench
===============================

// Module: lfsr_checker
// PURPOSE
//  Receive-side checker for the 8-bit Fibonacci LFSR pattern stream (x8 = x4^x3^x2^x0, right shift, feedback into bit 7).
//  Seeds a local predictor from the incoming stream, declares lock after consecutive matches, and flywheels through errors.
//  Counts mismatches while locked and drops lock after a run of bad samples.
//  Sits at the far end of a PRBS link or datapath under test; the generator drives one state per valid beat.
// PARAMETERS
//  LOCK_CNT    4   consecutive matches after seeding required to assert locked (>=1)
//  UNLOCK_CNT  3   consecutive mismatches while locked that force return to HUNT (>=1)
//  ERR_CNT_W   16  width of saturating error counter
// PORTS
//  clk        in   1          clock, rising edge
//  reset      in   1          reset, asynchronous, active-low
//  in_valid   in   1          in_data carries one LFSR state this cycle
//  in_data    in   8          received LFSR state
//  err_clr    in   1          synchronous clear of err_count
//  locked     out  1          checker locked to stream (registered)
//  err_pulse  out  1          one-cycle pulse: previous valid sample mismatched while LOCKED (registered)
//  err_count  out  ERR_CNT_W  saturating mismatch count while LOCKED
//  sync_state out  2          00 HUNT, 01 TRACK, 10 LOCKED (debug)
// BEHAVIOUR
//  Reset (reset=0, async): state HUNT, expected=8'h01, match_run=0, bad_run=0; locked=0, err_pulse=0, err_count=0.
//  Predictor step: next(s) = {s[4]^s[3]^s[2]^s[0], s[7:1]}; next(8'h00) = 8'h01 (matches generator anti-lockup).
//  in_valid=0: all state holds; err_pulse=0 next cycle. Only valid beats advance anything.
//  HUNT: valid & in_data!=0 -> expected<=next(in_data), match_run<=0, go TRACK. in_data==0 ignored (stay HUNT).
//  TRACK: valid & in_data==expected -> match_run++, expected<=next(expected); when match_run reaches LOCK_CNT go LOCKED.
//         valid & mismatch -> reseed: expected<=next(in_data), match_run<=0, stay TRACK (no err_pulse, no count).
//  LOCKED: expected<=next(expected) on every valid beat regardless of match (flywheel, no reseed).
//         match -> bad_run<=0. mismatch -> err_pulse=1 next cycle, err_count++ (saturate at all-ones), bad_run++;
//         bad_run reaching UNLOCK_CNT -> HUNT, locked<=0, bad_run<=0, match_run<=0.
//  locked = (state==LOCKED), registered: rises the cycle after the LOCK_CNT-th matching beat is sampled.
//  Latency: sample at edge N -> err_pulse/err_count/locked updated visible after edge N (one register stage).
//  err_clr & mismatch same cycle: clear then increment -> err_count=1. err_clr alone -> 0. err_clr never affects lock.
//  Saturation: err_count stays at 2^ERR_CNT_W-1; err_pulse still fires.
//  Reset mid-operation: outputs drop to reset values asynchronously; re-hunt from next valid after release.
// STRUCTURE
//  Package lfsr_pkg: LFSR_W=8, LFSR_SEED=8'h01, LFSR_TAPS=8'h1D, function lfsr_next(s) incl. zero->seed rule,
//   sync-state enum {HUNT,TRACK,LOCKED}. Generator side to reuse the same function.
//  One sub-module: lfsr_predict (expected register, load/advance controls, next-state output).
//  Top holds FSM, match_run/bad_run counters, error counter, output registers.
// TESTING
//  T1 lock: reset, valid 01,80,40,20,10 -> locked=1 cycle after 10 sampled, err_count=0, sync_state=10.
//  T2 single error: locked, send 00 in place of 88, then C4 -> one err_pulse, err_count=1, locked stays 1, C4 matches.
//  T3 loss of lock: locked, 3 consecutive bad beats -> err_count=3, locked=0 after 3rd, sync_state=00; good stream relocks after 1+4 beats.
//  T4 gaps/zero: in_valid low 5 cycles mid-stream -> no state change; in HUNT, in_data=00 valid -> stays HUNT.
//  T5 counter: ERR_CNT_W=2, 5 isolated errors while locked -> err_count=3, 5 pulses; err_clr with mismatch -> err_count=1.
//  T6 async reset while LOCKED with err_count=2 -> locked=0, err_count=0, err_pulse=0 before next clk edge.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit Fibonacci LFSR pattern (generator and checker).
// Contents: LFSR width/seed/taps, lfsr_next() step function, sync-state enum.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(8'h01);
  // Taps at bits 0,2,3,4: feedback = s[4]^s[3]^s[2]^s[0], shifted into bit 7.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(8'h1D);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    TRACK  = 2'b01,
    LOCKED = 2'b10
  } sync_state_e;

  // One right-shift step; all-zero state escapes to the seed (anti-lockup).
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    if (s == '0) begin
      return LFSR_SEED;
    end
    return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Stream and status bundle between an LFSR source/host and lfsr_checker.
// master: drives in_valid/in_data/err_clr, observes status.
// slave : the checker, receives the stream and drives status.
interface lfsr_checker_if #(
  parameter int unsigned ERR_CNT_W = 16
);
  import lfsr_pkg::*;

  logic                 in_valid;
  logic [LFSR_W-1:0]    in_data;
  logic                 err_clr;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_CNT_W-1:0] err_count;
  logic [1:0]           sync_state;

  modport master (
    output in_valid, in_data, err_clr,
    input  locked, err_pulse, err_count, sync_state
  );

  modport slave (
    input  in_valid, in_data, err_clr,
    output locked, err_pulse, err_count, sync_state
  );

endinterface

// File: rtl/lfsr_predict.sv
// Expected-value register for the LFSR checker.
// Ports: clk, reset (async, active-low), load (seed from load_data),
//        advance (step current value), load_data, expected (current prediction).
module lfsr_predict
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [LFSR_W-1:0] load_data,
  output logic [LFSR_W-1:0] expected
);

  logic [LFSR_W-1:0] expected_d, expected_q;

  // Load takes priority: predict the state that follows the received sample.
  always_comb begin
    expected_d = expected_q;
    if (load) begin
      expected_d = lfsr_next(load_data);
    end else if (advance) begin
      expected_d = lfsr_next(expected_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expected_q <= LFSR_SEED;
    end else begin
      expected_q <= expected_d;
    end
  end

  assign expected = expected_q;

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit LFSR pattern stream: seeds, locks after
// LOCK_CNT matches, flywheels while locked, counts errors, drops lock after
// UNLOCK_CNT consecutive bad samples.
// Ports: clk, reset (async, active-low), bus (lfsr_checker_if.slave):
//   in_valid/in_data/err_clr in; locked/err_pulse/err_count/sync_state out.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3,
  parameter int unsigned ERR_CNT_W  = 16
) (
  input  logic           clk,
  input  logic           reset,
  lfsr_checker_if.slave  bus
);

  localparam int unsigned RUN_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);

  sync_state_e          state_d, state_q;
  logic [RUN_W-1:0]     match_run_d, match_run_q;
  logic [RUN_W-1:0]     bad_run_d, bad_run_q;
  logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;
  logic                 err_pulse_d, err_pulse_q;
  logic                 locked_d, locked_q;

  logic                 pred_load, pred_adv;
  logic [LFSR_W-1:0]    expected;
  logic                 is_match;

  lfsr_predict u_predict (
    .clk       (clk),
    .reset     (reset),
    .load      (pred_load),
    .advance   (pred_adv),
    .load_data (bus.in_data),
    .expected  (expected)
  );

  assign is_match = (bus.in_data == expected);

  // Sync FSM, run counters and error counter; only valid beats advance state.
  always_comb begin
    state_d     = state_q;
    match_run_d = match_run_q;
    bad_run_d   = bad_run_q;
    err_pulse_d = 1'b0;
    pred_load   = 1'b0;
    pred_adv    = 1'b0;
    // Clear first so a same-cycle mismatch still lands as a count of one.
    err_cnt_d   = bus.err_clr ? '0 : err_cnt_q;

    if (bus.in_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.in_data != '0) begin
            pred_load   = 1'b1;
            match_run_d = '0;
            state_d     = TRACK;
          end
        end
        TRACK: begin
          if (is_match) begin
            pred_adv = 1'b1;
            if (match_run_q == RUN_W'(LOCK_CNT - 1)) begin
              match_run_d = '0;
              state_d     = LOCKED;
            end else begin
              match_run_d = match_run_q + RUN_W'(1);
            end
          end else begin
            pred_load   = 1'b1;
            match_run_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: keep predicting from our own sequence, never reseed.
          pred_adv = 1'b1;
          if (is_match) begin
            bad_run_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_cnt_d != '1) begin
              err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
            end
            if (bad_run_q == RUN_W'(UNLOCK_CNT - 1)) begin
              bad_run_d   = '0;
              match_run_d = '0;
              state_d     = HUNT;
            end else begin
              bad_run_d = bad_run_q + RUN_W'(1);
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= HUNT;
      match_run_q <= '0;
      bad_run_q   <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_run_q <= match_run_d;
      bad_run_q   <= bad_run_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
    end
  end

  assign bus.locked     = locked_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_count  = err_cnt_q;
  assign bus.sync_state = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: two instances (16-bit and 2-bit error counters) fed
// the same stream, compared every cycle against a behavioural reference model.
module tb_lfsr_checker;

  localparam int LOCK   = 4;
  localparam int UNLOCK = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  lfsr_checker_if #(.ERR_CNT_W(16)) bus16 ();
  lfsr_checker_if #(.ERR_CNT_W(2))  bus2 ();

  lfsr_checker #(.LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK), .ERR_CNT_W(16)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  lfsr_checker #(.LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK), .ERR_CNT_W(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: 0 hunting, 1 tracking, 2 locked.
  int m_state, m_exp, m_match, m_bad, m_c16, m_c2;
  bit m_pulse;
  int g;  // stream generator state

  function automatic int nx(input int s);
    int fb;
    if (s == 0) return 1;
    fb = ((s >> 4) ^ (s >> 3) ^ (s >> 2) ^ s) & 1;
    return ((s >> 1) | (fb << 7)) & 255;
  endfunction

  task automatic model_reset();
    m_state = 0; m_exp = 1; m_match = 0; m_bad = 0;
    m_c16 = 0; m_c2 = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit clr);
    m_pulse = 0;
    if (clr) begin
      m_c16 = 0;
      m_c2  = 0;
    end
    if (v) begin
      case (m_state)
        0: if (d != 0) begin
             m_exp = nx(d); m_match = 0; m_state = 1;
           end
        1: if (d == m_exp) begin
             m_match++;
             m_exp = nx(m_exp);
             if (m_match == LOCK) begin
               m_state = 2; m_match = 0;
             end
           end else begin
             m_exp = nx(d); m_match = 0;
           end
        default: begin
          if (d == m_exp) begin
            m_bad = 0;
          end else begin
            m_pulse = 1;
            if (m_c16 < 65535) m_c16++;
            if (m_c2 < 3) m_c2++;
            m_bad++;
            if (m_bad == UNLOCK) begin
              m_state = 0; m_bad = 0; m_match = 0;
            end
          end
          m_exp = nx(m_exp);
        end
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [1:0] ss;
    ss = (m_state == 2) ? 2'b10 : (m_state == 1) ? 2'b01 : 2'b00;
    check({tag, ".locked"},     32'(bus16.locked),     32'(m_state == 2));
    check({tag, ".sync_state"}, 32'(bus16.sync_state), 32'(ss));
    check({tag, ".err_pulse"},  32'(bus16.err_pulse),  32'(m_pulse));
    check({tag, ".err_count"},  32'(bus16.err_count),  32'(m_c16));
    check({tag, ".locked_w2"},  32'(bus2.locked),      32'(m_state == 2));
    check({tag, ".pulse_w2"},   32'(bus2.err_pulse),   32'(m_pulse));
    check({tag, ".count_w2"},   32'(bus2.err_count),   32'(m_c2));
  endtask

  task automatic send(input bit v, input logic [7:0] d, input bit clr, input string tag);
    bus16.in_valid = v; bus16.in_data = d; bus16.err_clr = clr;
    bus2.in_valid  = v; bus2.in_data  = d; bus2.err_clr  = clr;
    @(posedge clk);
    model_step(v, int'(d), clr);
    #1;
    check_all(tag);
  endtask

  task automatic good(input string tag);
    send(1'b1, 8'(g), 1'b0, tag);
    g = nx(g);
  endtask

  task automatic bad(input string tag);
    send(1'b1, 8'(g) ^ 8'($urandom_range(1, 255)), 1'b0, tag);
    g = nx(g);
  endtask

  task automatic idle(input string tag);
    send(1'b0, 8'($urandom_range(0, 255)), 1'b0, tag);
  endtask

  initial begin
    bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.err_clr = 1'b0;
    bus2.in_valid  = 1'b0; bus2.in_data  = '0; bus2.err_clr  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // T1: lock from seed 01
    g = 1;
    repeat (5) good("t1");
    check("t1_locked_const", 32'(bus16.locked), 32'd1);
    check("t1_state_const", 32'(bus16.sync_state), 32'd2);

    // T2: single error (00 where 88 is due), then C4 matches
    check("t2_gen_88", 32'(g), 32'h88);
    send(1'b1, 8'h00, 1'b0, "t2_err");
    g = nx(g);
    check("t2_pulse_const", 32'(bus16.err_pulse), 32'd1);
    good("t2_c4");
    repeat (3) good("t2_run");

    // T4: gaps mid-stream
    repeat (5) idle("t4_gap");
    repeat (3) good("t4_resume");

    // T3: loss of lock and relock
    repeat (3) bad("t3_bad");
    check("t3_unlocked_const", 32'(bus16.sync_state), 32'd0);
    repeat (5) good("t3_relock");
    check("t3_relocked_const", 32'(bus16.locked), 32'd1);

    // T4b: zero data while hunting is ignored
    repeat (3) bad("t4b_drop");
    repeat (3) send(1'b1, 8'h00, 1'b0, "t4b_zero");
    check("t4b_hunt_const", 32'(bus16.sync_state), 32'd0);
    repeat (5) good("t4b_relock");

    // T5: saturation on 2-bit counter, clear with mismatch, clear alone
    send(1'b0, 8'h00, 1'b1, "t5_clr");
    repeat (5) begin
      bad("t5_err");
      good("t5_ok");
    end
    check("t5_sat_const", 32'(bus2.err_count), 32'd3);
    send(1'b1, 8'(g) ^ 8'h5A, 1'b1, "t5_clr_err");
    g = nx(g);
    check("t5_clr_err_const", 32'(bus16.err_count), 32'd1);
    good("t5_ok2");
    send(1'b0, 8'h00, 1'b1, "t5_clr_alone");

    // Randomized stream: gaps, corrupted beats, occasional clears
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 15) begin
        send(1'b0, 8'($urandom_range(0, 255)), ($urandom_range(0, 19) == 0), "rnd_idle");
      end else if (r < 27) begin
        send(1'b1, 8'(g) ^ 8'($urandom_range(1, 255)), ($urandom_range(0, 19) == 0), "rnd_bad");
        g = nx(g);
      end else if (r < 29) begin
        send(1'b1, 8'($urandom_range(0, 255)), 1'b0, "rnd_any");
        g = nx(g);
      end else begin
        send(1'b1, 8'(g), ($urandom_range(0, 29) == 0), "rnd_good");
        g = nx(g);
      end
    end

    // T6: async reset while locked with err_count=2
    repeat (10) good("t6_lock");
    send(1'b0, 8'h00, 1'b1, "t6_clr");
    bad("t6_e1");
    good("t6_g1");
    bad("t6_e2");
    check("t6_pre_count", 32'(bus16.err_count), 32'd2);
    check("t6_pre_locked", 32'(bus16.locked), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("t6_rst_locked", 32'(bus16.locked), 32'd0);
    check("t6_rst_count", 32'(bus16.err_count), 32'd0);
    check("t6_rst_pulse", 32'(bus16.err_pulse), 32'd0);
    check("t6_rst_state", 32'(bus16.sync_state), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) good("t6_relock");
    check("t6_relocked", 32'(bus16.locked), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
